maze_port_arbiter: RTL and testbench

Two-requester arbiter for the single synchronous port of the maze memory (row/col address, output enable, write enable, one-bit read data). It sits between the maze solver (requester 0) and a second agent such as a maze loader or display scanner (requester 1). It grants one access per cycle with round-robin fairness, registers the winning command onto the memory port, and returns read data with fixed latency. An optional lock lets one requester hold the port for read-modify-write sequences.

---
 rtl/maze_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/maze_port_arbiter.sv | 115 +++++++++++
 tb/tb_maze_port_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared constants for the maze memory port: default address width, requester IDs, lock states.
package maze_pkg;
    localparam int MAZE_WIDTH = 6;
    localparam int REQ_SOLVER = 0;
    localparam int REQ_AUX    = 1;

    typedef enum logic [1:0] {
        LK_UNLOCKED = 2'd0,
        LK_LOCKED0  = 2'd1,
        LK_LOCKED1  = 2'd2
    } lock_state_e;
endpackage

// File: rtl/rr_arbiter2.sv
// 2-way round-robin pick (combinational, 0 cycles) plus last-winner pointer; never stalls,
// loser simply waits. Grants are forced to zero while rst is high.
module rr_arbiter2
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_gnt_q, last_gnt_d;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie goes to whoever did not win the previous transfer.
                2'b11:   gnt = last_gnt_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        last_gnt_d = last_gnt_q;
        if (gnt[REQ_SOLVER])
            last_gnt_d = 1'b0;
        else if (gnt[REQ_AUX])
            last_gnt_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_gnt_q <= 1'b1;
        else
            last_gnt_q <= last_gnt_d;
    end
endmodule

// File: rtl/maze_port_arbiter.sv
// Arbitrates two requesters onto the maze memory port: command registered 1 cycle after accept,
// read data 2 cycles after; never stalls. Optional requester lock under `ifdef MAZE_ARB_LOCK_EN.
module maze_port_arbiter
    import maze_pkg::*;
#(
    parameter int maze_width = MAZE_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req,
    input  logic [1:0]              we,
    input  logic [2*maze_width-1:0] row_req,
    input  logic [2*maze_width-1:0] col_req,
`ifdef MAZE_ARB_LOCK_EN
    input  logic [1:0]              lock,
`endif
    output logic [1:0]              gnt,
    output logic [1:0]              rvalid,
    output logic                    rdata,
    output logic [maze_width-1:0]   row,
    output logic [maze_width-1:0]   col,
    output logic                    maze_oe,
    output logic                    maze_we,
    input  logic                    maze_in
);
    logic [1:0]            req_eff;
    logic                  xfer, win;
    logic [maze_width-1:0] row_q, row_d, col_q, col_d;
    logic                  oe_q, oe_d, mwe_q, mwe_d;
    logic                  rd_vld_q, rd_vld_d, rd_own_q, rd_own_d;
    logic [1:0]            rvalid_q, rvalid_d;

`ifdef MAZE_ARB_LOCK_EN
    lock_state_e lock_q, lock_d;

    always_comb begin
        req_eff = req;
        case (lock_q)
            LK_LOCKED0: req_eff = req & 2'b01;
            LK_LOCKED1: req_eff = req & 2'b10;
            default:    req_eff = req;
        endcase
        // Every transfer re-decides the lock from the winner's lock bit.
        lock_d = lock_q;
        if (gnt[REQ_SOLVER])
            lock_d = lock[REQ_SOLVER] ? LK_LOCKED0 : LK_UNLOCKED;
        else if (gnt[REQ_AUX])
            lock_d = lock[REQ_AUX] ? LK_LOCKED1 : LK_UNLOCKED;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lock_q <= LK_UNLOCKED;
        else
            lock_q <= lock_d;
    end
`else
    assign req_eff = req;
`endif

    rr_arbiter2 u_rr (
        .clk (clk),
        .rst (rst),
        .req (req_eff),
        .gnt (gnt)
    );

    assign xfer = |gnt;
    assign win  = gnt[REQ_AUX];

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        oe_d  = 1'b0;
        mwe_d = 1'b0;
        if (xfer) begin
            row_d = win ? row_req[2*maze_width-1:maze_width] : row_req[maze_width-1:0];
            col_d = win ? col_req[2*maze_width-1:maze_width] : col_req[maze_width-1:0];
            oe_d  = ~we[win];
            mwe_d = we[win];
        end
        rd_vld_d = oe_d;
        rd_own_d = win;
        rvalid_d             = 2'b00;
        rvalid_d[REQ_SOLVER] = rd_vld_q & ~rd_own_q;
        rvalid_d[REQ_AUX]    = rd_vld_q & rd_own_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            oe_q     <= 1'b0;
            mwe_q    <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_own_q <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            row_q    <= row_d;
            col_q    <= col_d;
            oe_q     <= oe_d;
            mwe_q    <= mwe_d;
            rd_vld_q <= rd_vld_d;
            rd_own_q <= rd_own_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign maze_oe = oe_q;
    assign maze_we = mwe_q;
    assign rvalid  = rvalid_q;
    assign rdata   = maze_in;
endmodule

// File: tb/tb_maze_port_arbiter.sv
// Randomized scoreboard bench for maze_port_arbiter against a queue-based port model and memory.
module tb_maze_port_arbiter;
    localparam int W = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       req, we, lock, gnt, rvalid;
    logic [2*W-1:0]   row_req, col_req;
    logic             rdata, maze_oe, maze_we, maze_in;
    logic [W-1:0]     row, col;

    always #5 clk = ~clk;

    maze_port_arbiter #(.maze_width(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .row_req (row_req),
        .col_req (col_req),
`ifdef MAZE_ARB_LOCK_EN
        .lock    (lock),
`endif
        .gnt     (gnt),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .row     (row),
        .col     (col),
        .maze_oe (maze_oe),
        .maze_we (maze_we),
        .maze_in (maze_in)
    );

    typedef struct { logic w; logic [W-1:0] r; logic [W-1:0] c; logic lk; } cmd_t;
    typedef struct { int cyc; logic oe; logic w; logic [W-1:0] r; logic [W-1:0] c; } exp_cmd_t;
    typedef struct { int cyc; logic [1:0] rv; logic d; } exp_rd_t;

    cmd_t     src_q[2][$];
    exp_cmd_t cmd_q[$];
    exp_rd_t  rd_q[$];
    logic     mem[64][64];
    logic     ref_mem[64][64];
    int       cyc = 0;
    int       n_cmp = 0, n_bad = 0;
    int       m_last = 1, m_lock = -1;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural synchronous memory: data appears the cycle after maze_oe; writes store a marker.
    always @(posedge clk) begin
        if (maze_we) mem[row][col] <= 1'b1;
        if (maze_oe) maze_in <= mem[row][col];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Driver + port model: presents queue heads, predicts the grant, records expected responses.
    initial begin
        logic [1:0] exp_g;
        logic       el0, el1;
        int         w;
        cmd_t       c;
        req = 2'b00; we = 2'b00; lock = 2'b00; row_req = '0; col_req = '0;
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                if (src_q[i].size() > 0) begin
                    req[i]            = 1'b1;
                    we[i]             = src_q[i][0].w;
                    lock[i]           = src_q[i][0].lk;
                    row_req[i*W +: W] = src_q[i][0].r;
                    col_req[i*W +: W] = src_q[i][0].c;
                end else begin
                    req[i] = 1'b0;
                end
            end
            @(negedge clk);
            exp_g = 2'b00;
            if (!rst) begin
                el0 = req[0] && (m_lock < 0 || m_lock == 0);
                el1 = req[1] && (m_lock < 0 || m_lock == 1);
                if (el0 && el1) exp_g = (m_last == 1) ? 2'b01 : 2'b10;
                else if (el0)   exp_g = 2'b01;
                else if (el1)   exp_g = 2'b10;
            end
            check("gnt", {30'd0, gnt}, {30'd0, exp_g});
            if (exp_g != 2'b00) begin
                w = exp_g[1] ? 1 : 0;
                c = src_q[w].pop_front();
                cmd_q.push_back('{cyc + 1, ~c.w, c.w, c.r, c.c});
                if (!c.w) rd_q.push_back('{cyc + 2, exp_g, ref_mem[c.r][c.c]});
                else      ref_mem[c.r][c.c] = 1'b1;
                m_last = w;
                m_lock = c.lk ? w : -1;
            end
        end
    end

    // Monitor: compares the memory port and read return every cycle against the expected queues.
    initial begin
        logic [W-1:0] er, ec;
        exp_cmd_t     e;
        exp_rd_t      d;
        er = '0; ec = '0;
        forever begin
            @(posedge clk); #2;
            if (rst) begin
                er = '0; ec = '0;
                check("reset_port", {18'd0, maze_oe, maze_we, row, col}, 32'd0);
                check("reset_rvalid", {30'd0, rvalid}, 32'd0);
            end else begin
                e = '{cyc, 1'b0, 1'b0, er, ec};
                if (cmd_q.size() > 0 && cmd_q[0].cyc == cyc) e = cmd_q.pop_front();
                check("mem_cmd", {18'd0, maze_oe, maze_we, row, col}, {18'd0, e.oe, e.w, e.r, e.c});
                er = e.r; ec = e.c;
                if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                    d = rd_q.pop_front();
                    check("rvalid", {30'd0, rvalid}, {30'd0, d.rv});
                    check("rdata", {31'd0, rdata}, {31'd0, d.d});
                end else begin
                    check("rvalid_idle", {30'd0, rvalid}, 32'd0);
                end
            end
        end
    end

    task automatic push(input int i, input logic w, input int r, input int c, input logic lk);
        src_q[i].push_back('{w, r[W-1:0], c[W-1:0], lk});
    endtask

    task automatic drain(input int bound);
        int t = 0;
        while ((src_q[0].size() > 0 || src_q[1].size() > 0) && t < bound) begin
            @(posedge clk);
            t++;
        end
        check("drain_timeout", {31'd0, t >= bound}, 32'd0);
        repeat (4) @(posedge clk);
        #3;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cmd_q.delete(); rd_q.delete();
        m_last = 1; m_lock = -1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        int t;
        logic v;
        for (int r = 0; r < 64; r++)
            for (int c = 0; c < 64; c++) begin
                v = 1'($urandom_range(0, 1));
                mem[r][c] = v; ref_mem[r][c] = v;
            end
        mem[7][2] = 1'b0; ref_mem[7][2] = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;

        push(0, 1'b0, 3, 5, 1'b0);
        drain(50);

        for (int k = 0; k < 2; k++) begin
            push(0, 1'b0, 10 + k, 20 + k, 1'b0);
            push(1, 1'b0, 30 + k, 40 + k, 1'b0);
        end
        drain(50);

        push(1, 1'b1, 7, 2, 1'b0);
        drain(50);
        push(0, 1'b0, 7, 2, 1'b0);
        drain(50);
        repeat (3) @(posedge clk);
        #3;

        push(0, 1'b0, 4, 4, 1'b0);
        t = 0;
        while (src_q[0].size() > 0 && t < 50) begin
            @(negedge clk); #1;
            t++;
        end
        check("reset_accept_timeout", {31'd0, t >= 50}, 32'd0);
        pulse_reset();
        repeat (4) @(posedge clk);
        #3;

`ifdef MAZE_ARB_LOCK_EN
        push(1, 1'b0, 9, 9, 1'b0);
        push(0, 1'b0, 1, 1, 1'b1);
        push(0, 1'b0, 1, 1, 1'b1);
        push(0, 1'b0, 1, 1, 1'b0);
        drain(50);
`endif

        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #3;
            for (int i = 0; i < 2; i++) begin
                if (src_q[i].size() < 2 && $urandom_range(0, 2) != 0) begin
                    if ($urandom_range(0, 1) == 1)
                        push(i, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
`ifdef MAZE_ARB_LOCK_EN
                             1'($urandom_range(0, 3) == 0));
`else
                             1'b0);
`endif
                    else
                        push(i, 1'($urandom_range(0, 1)), $urandom_range(0, 63), $urandom_range(0, 63), 1'b0);
                end
            end
        end
        drain(1000);

        check("cmd_q_left", cmd_q.size(), 32'd0);
        check("rd_q_left", rd_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
